// File: rtl/mem_stage_pkg.sv
// mem_stage_pkg: opcodes, access-size encoding, FSM states and decode helpers for the MEM stage
package mem_stage_pkg;
  localparam logic [5:0] OPCODE_LB  = 6'h20;
  localparam logic [5:0] OPCODE_LH  = 6'h21;
  localparam logic [5:0] OPCODE_LW  = 6'h23;
  localparam logic [5:0] OPCODE_LBU = 6'h24;
  localparam logic [5:0] OPCODE_LHU = 6'h25;
  localparam logic [5:0] OPCODE_SB  = 6'h28;
  localparam logic [5:0] OPCODE_SH  = 6'h29;
  localparam logic [5:0] OPCODE_SW  = 6'h2B;

  typedef enum logic [1:0] {SIZE_BYTE = 2'd0, SIZE_HALF = 2'd1, SIZE_WORD = 2'd2} size_t;
  typedef enum logic {IDLE, WAIT} state_t;

  function automatic size_t size_of(input logic [5:0] op);
    return (op == OPCODE_LB || op == OPCODE_LBU || op == OPCODE_SB) ? SIZE_BYTE
         : (op == OPCODE_LH || op == OPCODE_LHU || op == OPCODE_SH) ? SIZE_HALF : SIZE_WORD;
  endfunction

  function automatic logic is_unsigned(input logic [5:0] op);
    return op == OPCODE_LBU || op == OPCODE_LHU;
  endfunction
endpackage

// File: rtl/mem_stage_data_memory.sv
// data_memory: word RAM with byte-enabled synchronous write and two combinational read ports
module data_memory #(
  parameter int DEPTH = 256,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          we,
  input  logic [3:0]    be,
  input  logic [AW-1:0] addr,
  input  logic [31:0]   wdata,
  output logic [31:0]   rdata,
  input  logic [AW-1:0] dbg_addr,
  output logic [31:0]   dbg_data
);
  logic [31:0] mem [DEPTH];
  always_ff @(posedge clk)
    for (int i = 0; i < 4; i++)
      if (we && be[i]) mem[addr][8*i +: 8] <= wdata[8*i +: 8];
  assign rdata    = mem[addr];
  assign dbg_data = mem[dbg_addr];
endmodule

// File: rtl/mem_stage.sv
// mem_stage: MIPS MEM stage with wait-state FSM, load extend/store lanes and MEM/WB register
module mem_stage
  import mem_stage_pkg::*;
#(
  parameter int MEM_DEPTH   = 256,
  parameter int MEM_LATENCY = 0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] i_alu_result,
  input  logic [31:0] i_write_data,
  input  logic [4:0]  i_write_register,
  input  logic [5:0]  i_opcode,
  input  logic        i_reg_write,
  input  logic        i_mem_read,
  input  logic        i_mem_write,
  input  logic        i_mem_to_reg,
  input  logic        i_is_jal,
  input  logic [31:0] i_pc_plus_4,
  input  logic [31:0] i_debug_addr,
  output logic [31:0] o_read_data,
  output logic [31:0] o_alu_result,
  output logic [4:0]  o_write_register,
  output logic        o_reg_write,
  output logic        o_mem_to_reg,
  output logic        o_is_jal,
  output logic [31:0] o_pc_plus_4,
  output logic        o_stall,
  output logic        o_misaligned,
  output logic [31:0] o_debug_data
);
  localparam int AW = $clog2(MEM_DEPTH);
  localparam logic [2:0] LAT = 3'(MEM_LATENCY);
  state_t state, state_n;
  logic [2:0] cnt, cnt_n;
  logic [1:0] a;
  size_t size;
  logic uns, access, mis, start, commit;
  logic [3:0] be;
  logic [15:0] lane;
  logic [31:0] word, ext, wdata, load_data;
  logic unused;
  assign a      = i_alu_result[1:0];
  assign size   = size_of(i_opcode);
  assign uns    = is_unsigned(i_opcode);
  assign access = i_mem_read | i_mem_write;
  assign mis    = access && ((size == SIZE_HALF && a[0]) || (size == SIZE_WORD && a != 2'b00));
  assign unused = ^{i_debug_addr[31:AW+2], i_debug_addr[1:0]};
  // Stall is masked by reset so an aborted access releases the pipeline immediately.
  always_comb begin
    start   = state == IDLE && access && LAT != 3'd0;
    commit  = state == IDLE ? !start : cnt == 3'd0;
    state_n = start ? WAIT : commit ? IDLE : state;
    cnt_n   = start ? LAT - 3'd1 : !commit ? cnt - 3'd1 : cnt;
    o_stall = !reset && !commit;
  end
  always_comb begin
    lane      = 16'(word >> {a, 3'b000});
    ext       = size == SIZE_BYTE ? {{24{lane[7] & ~uns}}, lane[7:0]}
              : size == SIZE_HALF ? {{16{lane[15] & ~uns}}, lane[15:0]} : word;
    load_data = i_mem_read && !i_mem_write && !mis ? ext : '0;
    be        = !i_mem_write || mis ? 4'b0000
              : size == SIZE_BYTE ? 4'b0001 << a
              : size == SIZE_HALF ? (a[1] ? 4'b1100 : 4'b0011) : 4'b1111;
    wdata     = size == SIZE_BYTE ? {4{i_write_data[7:0]}}
              : size == SIZE_HALF ? {2{i_write_data[15:0]}} : i_write_data;
  end
  data_memory #(.DEPTH(MEM_DEPTH), .AW(AW)) u_mem (
    .clk      (clk),
    .we       (commit && !reset),
    .be       (be),
    .addr     (i_alu_result[AW+1:2]),
    .wdata    (wdata),
    .rdata    (word),
    .dbg_addr (i_debug_addr[AW+1:2]),
    .dbg_data (o_debug_data)
  );
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state            <= IDLE;
      cnt              <= '0;
      o_read_data      <= '0;
      o_alu_result     <= '0;
      o_write_register <= '0;
      o_reg_write      <= 1'b0;
      o_mem_to_reg     <= 1'b0;
      o_is_jal         <= 1'b0;
      o_pc_plus_4      <= '0;
      o_misaligned     <= 1'b0;
    end else begin
      state            <= state_n;
      cnt              <= cnt_n;
      o_read_data      <= load_data;
      o_alu_result     <= i_alu_result;
      o_write_register <= i_write_register;
      o_reg_write      <= commit && i_reg_write && !mis;
      o_mem_to_reg     <= commit && i_mem_to_reg;
      o_is_jal         <= commit && i_is_jal;
      o_pc_plus_4      <= i_pc_plus_4;
      o_misaligned     <= commit && mis;
    end
endmodule

// File: tb/tb_mem_stage.sv
// tb_mem_stage: directed and random checks of mem_stage at latency 0 and 3 against a byte-level model
module tb_mem_stage;
  localparam logic [5:0] LB = 6'h20, LH = 6'h21, LW = 6'h23, LBU = 6'h24, LHU = 6'h25;
  localparam logic [5:0] SB = 6'h28, SH = 6'h29, SW = 6'h2B;

  typedef struct packed {
    logic [5:0] opc; logic [31:0] addr; logic [31:0] data; logic [4:0] rd;
    logic rw; logic mr; logic mw; logic mtr; logic jal; logic [31:0] pc4;
  } op_t;
  typedef struct packed {
    logic [31:0] rdata; logic [31:0] alu; logic [4:0] wreg;
    logic rw; logic mtr; logic jal; logic [31:0] pc4; logic mis;
  } wb_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst0, rst3;
  op_t in0, in3;
  logic [31:0] dbg0, dbg3, dd0, dd3, rd0, rd3, alu0, alu3, pc0, pc3;
  logic [4:0] wr0, wr3;
  logic rw0, rw3, mtr0, mtr3, jal0, jal3, mis0, mis3, st0, st3;
  wb_t obs0, obs3;
  assign obs0 = {rd0, alu0, wr0, rw0, mtr0, jal0, pc0, mis0};
  assign obs3 = {rd3, alu3, wr3, rw3, mtr3, jal3, pc3, mis3};

  mem_stage #(.MEM_DEPTH(256), .MEM_LATENCY(0)) d0 (
    .clk(clk), .reset(rst0), .i_alu_result(in0.addr), .i_write_data(in0.data),
    .i_write_register(in0.rd), .i_opcode(in0.opc), .i_reg_write(in0.rw), .i_mem_read(in0.mr),
    .i_mem_write(in0.mw), .i_mem_to_reg(in0.mtr), .i_is_jal(in0.jal), .i_pc_plus_4(in0.pc4),
    .i_debug_addr(dbg0), .o_read_data(rd0), .o_alu_result(alu0), .o_write_register(wr0),
    .o_reg_write(rw0), .o_mem_to_reg(mtr0), .o_is_jal(jal0), .o_pc_plus_4(pc0),
    .o_stall(st0), .o_misaligned(mis0), .o_debug_data(dd0));

  mem_stage #(.MEM_DEPTH(256), .MEM_LATENCY(3)) d3 (
    .clk(clk), .reset(rst3), .i_alu_result(in3.addr), .i_write_data(in3.data),
    .i_write_register(in3.rd), .i_opcode(in3.opc), .i_reg_write(in3.rw), .i_mem_read(in3.mr),
    .i_mem_write(in3.mw), .i_mem_to_reg(in3.mtr), .i_is_jal(in3.jal), .i_pc_plus_4(in3.pc4),
    .i_debug_addr(dbg3), .o_read_data(rd3), .o_alu_result(alu3), .o_write_register(wr3),
    .o_reg_write(rw3), .o_mem_to_reg(mtr3), .o_is_jal(jal3), .o_pc_plus_4(pc3),
    .o_stall(st3), .o_misaligned(mis3), .o_debug_data(dd3));

  int total = 0, bad = 0;
  logic [7:0] mb [2][1024];

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int nbytes(input logic [5:0] o);
    return (o == LB || o == LBU || o == SB) ? 1 : (o == LH || o == LHU || o == SH) ? 2 : 4;
  endfunction

  function automatic logic [31:0] mword(input int d, input logic [31:0] a);
    int b = int'(a[9:2]) * 4;
    return {mb[d][b+3], mb[d][b+2], mb[d][b+1], mb[d][b]};
  endfunction

  function automatic wb_t model_wb(input int d, input op_t op);
    wb_t e;
    int n = nbytes(op.opc);
    int base = int'(op.addr[9:0]);
    logic [31:0] v = '0;
    logic mis = (op.mr || op.mw) && (base % n != 0);
    for (int i = 0; i < n; i++) v |= 32'(mb[d][(base + i) % 1024]) << (8 * i);
    if (n < 4 && (op.opc == LB || op.opc == LH) && v[8*n-1]) v |= 32'hFFFFFFFF << (8 * n);
    e.rdata = (op.mr && !op.mw && !mis) ? v : 32'h0;
    e.alu   = op.addr;
    e.wreg  = op.rd;
    e.rw    = op.rw && !mis;
    e.mtr   = op.mtr;
    e.jal   = op.jal;
    e.pc4   = op.pc4;
    e.mis   = mis;
    return e;
  endfunction

  task automatic model_commit(input int d, input op_t op);
    int n = nbytes(op.opc);
    int base = int'(op.addr[9:0]);
    if (op.mw && base % n == 0)
      for (int i = 0; i < n; i++) mb[d][(base + i) % 1024] = op.data[8*i +: 8];
  endtask

  function automatic op_t mop(input logic [5:0] opc, input logic [31:0] addr, input logic [31:0] data);
    logic ld = opc == LB || opc == LH || opc == LW || opc == LBU || opc == LHU;
    return '{opc: opc, addr: addr, data: data, rd: 5'd8, rw: ld, mr: ld, mw: !ld,
             mtr: ld, jal: 1'b0, pc4: 32'h0000_0400};
  endfunction

  function automatic op_t aop(input logic [31:0] v);
    return '{opc: 6'h00, addr: v, data: 32'h0, rd: 5'd9, rw: 1'b1, mr: 1'b0, mw: 1'b0,
             mtr: 1'b0, jal: 1'b0, pc4: 32'h0};
  endfunction

  function automatic op_t rop();
    op_t o;
    logic [5:0] t [10];
    logic [31:0] a = $urandom;
    t = '{LB, LH, LW, LBU, LHU, SB, SH, SW, 6'h00, 6'h03};
    a[9:6] = 4'b0000;
    o = mop(t[$urandom_range(0, 9)], a, $urandom);
    if (o.opc == 6'h00) o = aop(a);
    if (o.opc == 6'h03) begin o = aop(a); o.opc = 6'h03; o.jal = 1'b1; o.rd = 5'd31; end
    if ((o.mr || o.mw) && $urandom_range(0, 7) == 0) begin o.mr = 1'b1; o.mw = 1'b1; end
    o.rd  = 5'($urandom);
    o.pc4 = $urandom;
    return o;
  endfunction

  function automatic logic stall_of(input int d);
    return d == 0 ? st0 : st3;
  endfunction

  task automatic run(input int d, input op_t op);
    wb_t e;
    int w = (d == 1 && (op.mr || op.mw)) ? 3 : 0;
    if (d == 0) begin in0 = op; dbg0 = {op.addr[31:2], 2'b00}; end
    else begin in3 = op; dbg3 = {op.addr[31:2], 2'b00}; end
    e = model_wb(d, op);
    for (int k = 0; k < w; k++) begin
      #1 chk("stall_high", 128'(stall_of(d)), 128'(1'b1));
      @(posedge clk);
      #1 chk("bubble_ctrl", 128'({rw3, mtr3, jal3, mis3}), 128'(4'b0000));
    end
    #1 chk(d == 0 ? "stall_low_lat0" : "stall_low_lat3", 128'(stall_of(d)), 128'(1'b0));
    model_commit(d, op);
    @(posedge clk);
    #1;
    chk(d == 0 ? "memwb_lat0" : "memwb_lat3", 128'(d == 0 ? obs0 : obs3), 128'(e));
    chk(d == 0 ? "debug_lat0" : "debug_lat3", 128'(d == 0 ? dd0 : dd3), 128'(mword(d, op.addr)));
    if (d == 0) in0 = aop(32'h0); else in3 = aop(32'h0);
  endtask

  initial begin
    rst0 = 1'b1; rst3 = 1'b1;
    in0 = aop(32'h0); in3 = aop(32'h0);
    dbg0 = '0; dbg3 = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_wb0", 128'(obs0), 128'(0));
    chk("reset_wb3", 128'(obs3), 128'(0));
    chk("reset_stall0", 128'(st0), 128'(0));
    chk("reset_stall3", 128'(st3), 128'(0));
    rst0 = 1'b0; rst3 = 1'b0;

    for (int w = 0; w < 16; w++) begin
      logic [31:0] v = $urandom;
      run(0, mop(SW, 32'(w * 4), v));
      run(1, mop(SW, 32'(w * 4), v));
    end

    run(0, mop(SW, 32'h10, 32'hDEADBEEF));
    run(0, mop(LW, 32'h10, 32'h0));
    chk("t1_lw", 128'({rd0, rw0, mtr0}), 128'({32'hDEADBEEF, 2'b11}));
    run(0, mop(SB, 32'h11, 32'h000000AB));
    chk("t2_sb_debug", 128'(dd0), 128'(32'hDEADABEF));
    run(0, mop(LBU, 32'h11, 32'h0));
    chk("t2_lbu", 128'(rd0), 128'(32'h000000AB));
    run(0, mop(LB, 32'h13, 32'h0));
    chk("t2_lb", 128'(rd0), 128'(32'hFFFFFFDE));
    run(0, mop(LH, 32'h12, 32'h0));
    chk("t3_lh", 128'(rd0), 128'(32'hFFFFDEAD));
    run(0, mop(LHU, 32'h12, 32'h0));
    chk("t3_lhu", 128'(rd0), 128'(32'h0000DEAD));
    run(0, mop(SH, 32'h10, 32'h00001234));
    chk("t3_sh_debug", 128'(dd0), 128'(32'hDEAD1234));

    run(1, mop(SW, 32'h10, 32'hDEADBEEF));
    run(1, mop(LW, 32'h10, 32'h0));
    chk("t4_lw_lat3", 128'({rd3, rw3}), 128'({32'hDEADBEEF, 1'b1}));
    run(1, aop(32'h0000_0077));
    chk("t4_add_next", 128'({alu3, rw3}), 128'({32'h77, 1'b1}));

    run(0, mop(SW, 32'h0E, 32'h55555555));
    chk("t5_sw_mis", 128'({mis0, rw0}), 128'(2'b10));
    run(0, aop(32'h5));
    chk("t5_mis_one_cycle", 128'(mis0), 128'(0));
    run(0, mop(LH, 32'h13, 32'h0));
    chk("t5_lh_mis", 128'({mis0, rd0}), 128'({1'b1, 32'h0}));
    run(1, mop(SH, 32'h21, 32'hABCD));
    chk("t5_mis_lat3", 128'({mis3, rw3}), 128'(2'b10));

    for (int i = 0; i < 80; i++) run(0, rop());
    for (int i = 0; i < 25; i++) run(1, rop());

    in3 = mop(SW, 32'h20, 32'hFFFFFFFF);
    dbg3 = 32'h20;
    #1 chk("t6_stall_a", 128'(st3), 128'(1));
    @(posedge clk);
    #1 chk("t6_stall_b", 128'(st3), 128'(1));
    @(posedge clk);
    #1 rst3 = 1'b1;
    #1;
    chk("t6_reset_wb", 128'(obs3), 128'(0));
    chk("t6_reset_stall", 128'(st3), 128'(0));
    in3 = aop(32'h0);
    @(posedge clk);
    #1 rst3 = 1'b0;
    #1;
    chk("t6_mem_unchanged", 128'(dd3), 128'(mword(1, 32'h20)));
    run(1, mop(LW, 32'h20, 32'h0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
